dmi_req_buffer: RTL and testbench



---
 rtl/dmi_req_buffer.sv | 189 ++++++++++++++++++
 tb/tb_dmi_req_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_req_buffer.sv
// Single-outstanding DMI request/response buffer between the DTM and the debug module.
// Define DMI_REQ_BUFFER_TIMEOUT_EN to add the response timeout and the stale-response drop.

package dm;
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;
endpackage

module dmi_req_buffer #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  dm::dmi_req_t  req_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  output dm::dmi_resp_t resp_o,
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output dm::dmi_req_t  dm_req_o,
  output logic          dm_req_valid_o,
  input  logic          dm_req_ready_i,
  input  dm::dmi_resp_t dm_resp_i,
  input  logic          dm_resp_valid_i,
  output logic          dm_resp_ready_o,
  output logic          busy_o,
  output logic          timeout_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]    state_q, state_d;
  dm::dmi_req_t  req_q, req_d;
  dm::dmi_resp_t resp_q, resp_d;

  // Every handshake output is a flop loaded from the next state, so nothing is combinational from inputs
  logic req_ready_q, req_ready_d;
  logic dm_req_valid_q, dm_req_valid_d;
  logic dm_resp_ready_q, dm_resp_ready_d;
  logic resp_valid_q, resp_valid_d;
  logic busy_q, busy_d;
  logic stale_hit;

`ifdef DMI_REQ_BUFFER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stale_q, stale_d;
  logic            timeout_q, timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TimeoutCycles);
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    resp_d    = resp_q;
    stale_hit = 1'b0;
`ifdef DMI_REQ_BUFFER_TIMEOUT_EN
    cnt_d     = '0;
    stale_d   = stale_q;
    timeout_d = 1'b0;
    // A response owed to an aborted transaction is swallowed before it can be mistaken for a new one
    stale_hit = stale_q & dm_resp_ready_q & dm_resp_valid_i;
    if (stale_hit) stale_d = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (req_ready_q && req_valid_i) begin
          req_d   = req_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (dm_req_ready_i) begin
          if (dm_resp_valid_i && !stale_hit) begin
            resp_d  = dm_resp_i;
            state_d = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (dm_resp_valid_i && !stale_hit) begin
          resp_d  = dm_resp_i;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef DMI_REQ_BUFFER_TIMEOUT_EN
    if (state_q == StIssue || state_q == StWait) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q >= CntLast && state_d == state_q) begin
        resp_d    = dm::dmi_resp_t'{data: 32'h0, resp: 2'd2};
        state_d   = StResp;
        timeout_d = 1'b1;
        if (state_q == StWait) stale_d = 1'b1;
      end
    end
`endif

    if (clear_i) begin
      state_d = StIdle;
      req_d   = '0;
      resp_d  = '0;
`ifdef DMI_REQ_BUFFER_TIMEOUT_EN
      cnt_d     = '0;
      stale_d   = 1'b0;
      timeout_d = 1'b0;
`endif
    end

    req_ready_d     = (state_d == StIdle) && !clear_i;
    dm_req_valid_d  = (state_d == StIssue);
    dm_resp_ready_d = (state_d == StIssue) || (state_d == StWait);
    resp_valid_d    = (state_d == StResp);
    busy_d          = (state_d != StIdle);
`ifdef DMI_REQ_BUFFER_TIMEOUT_EN
    dm_resp_ready_d = dm_resp_ready_d || stale_d;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      req_q           <= '0;
      resp_q          <= '0;
      req_ready_q     <= 1'b0;
      dm_req_valid_q  <= 1'b0;
      dm_resp_ready_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      busy_q          <= 1'b0;
`ifdef DMI_REQ_BUFFER_TIMEOUT_EN
      cnt_q           <= '0;
      stale_q         <= 1'b0;
      timeout_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      resp_q          <= resp_d;
      req_ready_q     <= req_ready_d;
      dm_req_valid_q  <= dm_req_valid_d;
      dm_resp_ready_q <= dm_resp_ready_d;
      resp_valid_q    <= resp_valid_d;
      busy_q          <= busy_d;
`ifdef DMI_REQ_BUFFER_TIMEOUT_EN
      cnt_q           <= cnt_d;
      stale_q         <= stale_d;
      timeout_q       <= timeout_d;
`endif
    end
  end

  assign req_ready_o     = req_ready_q;
  assign dm_req_o        = req_q;
  assign dm_req_valid_o  = dm_req_valid_q;
  assign dm_resp_ready_o = dm_resp_ready_q;
  assign resp_o          = resp_q;
  assign resp_valid_o    = resp_valid_q;
  assign busy_o          = busy_q;
`ifdef DMI_REQ_BUFFER_TIMEOUT_EN
  assign timeout_o       = timeout_q;
`else
  assign timeout_o       = 1'b0;
`endif

endmodule

// File: tb/tb_dmi_req_buffer.sv
// Bench for dmi_req_buffer: vector table of DMI transactions plus clear and timeout sequences.
`timescale 1ns/1ps

module tb_dmi_req_buffer;

  typedef struct {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
    int          ready_dly;
    int          resp_dly;
    logic [31:0] rdata;
    logic [1:0]  rcode;
    int          hold;
  } vec_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  dm::dmi_req_t  req;
  logic          req_valid;
  logic          req_ready;
  dm::dmi_resp_t resp;
  logic          resp_valid;
  logic          resp_ready;
  dm::dmi_req_t  dm_req;
  logic          dm_req_valid;
  logic          dm_req_ready;
  dm::dmi_resp_t dm_resp;
  logic          dm_resp_valid;
  logic          dm_resp_ready;
  logic          busy;
  logic          timeout;

  int tests = 0;
  int fails = 0;
  dm::dmi_resp_t sb_q[$];
  vec_t vecs[5];

  dmi_req_buffer #(.TimeoutCycles(16)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .req_i           (req),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .resp_o          (resp),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .dm_req_o        (dm_req),
    .dm_req_valid_o  (dm_req_valid),
    .dm_req_ready_i  (dm_req_ready),
    .dm_resp_i       (dm_resp),
    .dm_resp_valid_i (dm_resp_valid),
    .dm_resp_ready_o (dm_resp_ready),
    .busy_o          (busy),
    .timeout_o       (timeout)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic dm::dmi_resp_t junk_resp();
    return dm::dmi_resp_t'({$urandom(), 2'($urandom())});
  endfunction

  // Pop the next expected response and compare it with what the DUT presents
  task automatic sb_check(input string nm);
    dm::dmi_resp_t exp;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: response seen with empty scoreboard, got %h", nm, resp);
    end else begin
      exp = sb_q.pop_front();
      chk(nm, 64'(resp), 64'(exp));
    end
  endtask

  task automatic run_txn(input vec_t v);
    dm::dmi_req_t  exp_req;
    dm::dmi_resp_t exp_resp;
    int n = 0;
    exp_req  = '{addr: v.addr, op: v.op, data: v.data};
    exp_resp = '{data: v.rdata, resp: v.rcode};
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req       = exp_req;
    step();
    req_valid = 1'b0;
    req       = '0;
    chk("issue_valid", 64'(dm_req_valid), 64'd1);
    chk("issue_req", 64'(dm_req), 64'(exp_req));
    chk("issue_busy_noready", 64'({busy, req_ready}), 64'b10);
    repeat (v.ready_dly) step();
    chk("issue_held", 64'({dm_req_valid, dm_resp_ready}), 64'b11);
    dm_req_ready = 1'b1;
    if (v.resp_dly == 0) begin
      dm_resp_valid = 1'b1;
      dm_resp       = exp_resp;
      sb_q.push_back(exp_resp);
    end
    step();
    dm_req_ready  = 1'b0;
    dm_resp_valid = 1'b0;
    dm_resp       = junk_resp();
    if (v.resp_dly > 0) begin
      chk("wait_outs", 64'({dm_req_valid, dm_resp_ready, resp_valid}), 64'b010);
      repeat (v.resp_dly - 1) step();
      dm_resp_valid = 1'b1;
      dm_resp       = exp_resp;
      sb_q.push_back(exp_resp);
      chk("resp_not_early", 64'(resp_valid), 64'd0);
      step();
      dm_resp_valid = 1'b0;
      dm_resp       = junk_resp();
    end
    chk("resp_valid", 64'(resp_valid), 64'd1);
    chk("respond_dm_ready_low", 64'(dm_resp_ready), 64'd0);
    sb_check("resp_data");
    repeat (v.hold) begin
      step();
      chk("hold_resp_stable", 64'(resp), 64'(exp_resp));
      chk("hold_flags", 64'({resp_valid, req_ready}), 64'b10);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("back_idle", 64'({req_ready, busy, resp_valid}), 64'b100);
  endtask

  initial begin
    vecs[0] = '{addr: 7'h11, op: 2'd1, data: 32'h0,         ready_dly: 2, resp_dly: 3,
                rdata: 32'h0000_0C82, rcode: 2'd0, hold: 5};
    vecs[1] = '{addr: 7'h10, op: 2'd2, data: 32'h1,         ready_dly: 0, resp_dly: 0,
                rdata: 32'h0000_0001, rcode: 2'd0, hold: 0};
    vecs[2] = '{addr: 7'h04, op: 2'd1, data: 32'h0,         ready_dly: 1, resp_dly: 1,
                rdata: 32'hDEAD_BEEF, rcode: 2'd3, hold: 1};
    vecs[3] = '{addr: 7'h17, op: 2'd2, data: 32'h0000_A5A5, ready_dly: 0, resp_dly: 2,
                rdata: 32'h0000_0000, rcode: 2'd1, hold: 0};
    vecs[4] = '{addr: 7'h7F, op: 2'd1, data: 32'h0,         ready_dly: 3, resp_dly: 0,
                rdata: 32'h1234_5678, rcode: 2'd2, hold: 2};

    // Reset with random inputs toggling
    rst_ni = 1'b0;
    repeat (4) begin
      clear_i       = 1'($urandom());
      req           = dm::dmi_req_t'({7'($urandom()), 2'($urandom()), $urandom()});
      req_valid     = 1'($urandom());
      resp_ready    = 1'($urandom());
      dm_req_ready  = 1'($urandom());
      dm_resp       = junk_resp();
      dm_resp_valid = 1'($urandom());
      step();
      chk("reset_flags", 64'({req_ready, dm_req_valid, resp_valid, dm_resp_ready, busy, timeout}), 64'd0);
      chk("reset_buses", 64'({resp, dm_req}), 64'd0);
    end
    clear_i       = 1'b0;
    req           = '0;
    req_valid     = 1'b0;
    resp_ready    = 1'b0;
    dm_req_ready  = 1'b0;
    dm_resp       = '0;
    dm_resp_valid = 1'b0;
    rst_ni        = 1'b1;
    step();
    chk("post_reset", 64'({req_ready, busy}), 64'b10);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Clear while waiting for the response
    req_valid = 1'b1;
    req       = '{addr: 7'h05, op: 2'd1, data: 32'h0};
    step();
    req_valid    = 1'b0;
    dm_req_ready = 1'b1;
    step();
    dm_req_ready = 1'b0;
    chk("clr_pre", 64'({busy, dm_resp_ready, dm_req_valid}), 64'b110);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clr_flags", 64'({busy, dm_resp_ready, dm_req_valid, resp_valid, req_ready}), 64'd0);
    chk("clr_req_zeroed", 64'(dm_req), 64'd0);
    dm_resp_valid = 1'b1;
    dm_resp       = junk_resp();
    step();
    dm_resp_valid = 1'b0;
    chk("clr_stray_resp_ignored", 64'({req_ready, busy, resp_valid}), 64'b100);
    run_txn('{addr: 7'h21, op: 2'd2, data: 32'hCAFE_0001, ready_dly: 1, resp_dly: 2,
              rdata: 32'h0000_0042, rcode: 2'd0, hold: 1});

`ifdef DMI_REQ_BUFFER_TIMEOUT_EN
    begin
      int cyc = 0;
      req_valid = 1'b1;
      req       = '{addr: 7'h22, op: 2'd1, data: 32'h0};
      step();
      req_valid    = 1'b0;
      dm_req_ready = 1'b1;
      step();
      dm_req_ready = 1'b0;
      cyc = 1;
      while (!timeout && cyc < 40) begin
        step();
        cyc++;
      end
      chk("to_cycle", 64'(cyc), 64'd16);
      sb_q.push_back('{data: 32'h0, resp: 2'd2});
      chk("to_respond", 64'({resp_valid, dm_resp_ready}), 64'b11);
      sb_check("to_resp");
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk("to_after", 64'({timeout, req_ready, dm_resp_ready}), 64'b011);
      dm_resp_valid = 1'b1;
      dm_resp       = junk_resp();
      step();
      dm_resp_valid = 1'b0;
      chk("to_stale_drop", 64'({dm_resp_ready, resp_valid, busy}), 64'd0);
      run_txn('{addr: 7'h11, op: 2'd1, data: 32'h0, ready_dly: 0, resp_dly: 1,
                rdata: 32'h0000_0C82, rcode: 2'd0, hold: 0});
    end
`endif

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
